// File: rtl/omsp_spm_pkg.sv
// Shared encodings for the SPM protect/unprotect sequencer.
package omsp_spm_pkg;

  localparam int NB_SPMS_DFLT = 4;
  localparam int IDX_W_DFLT   = $clog2(NB_SPMS_DFLT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_VALIDATE = 3'd1,
    ST_SCAN     = 3'd2,
    ST_COMMIT   = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  localparam logic OP_PROTECT   = 1'b0;
  localparam logic OP_UNPROTECT = 1'b1;

  localparam logic [2:0] ERR_NONE      = 3'd0;
  localparam logic [2:0] ERR_LAYOUT    = 3'd1;
  localparam logic [2:0] ERR_OVERLAP   = 3'd2;
  localparam logic [2:0] ERR_FULL      = 3'd3;
  localparam logic [2:0] ERR_NOT_FOUND = 3'd4;

endpackage

// File: rtl/omsp_spm_range_cmp.sv
// Half-open overlap test: [a0,a1) and [b0,b1) share at least one address.
module omsp_spm_range_cmp (
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  output logic        hit
);

  assign hit = (a0 < b1) && (b0 < a1);

endmodule

// File: rtl/omsp_spm_protect_seq.sv
// Serial protect/unprotect sequencer: scans one SPM slot per cycle, then strobes a write or clear.
//   state    | meaning
//   IDLE     | waiting for start; operands captured on start
//   VALIDATE | check public/secret layout of the new request
//   SCAN     | walk slots 0..NB_SPMS-1, overlap check / first-free / pc owner
//   COMMIT   | slot_wr or slot_clr strobe on the target slot
//   DONE     | done pulse, result on ok/err
module omsp_spm_protect_seq
  import omsp_spm_pkg::*;
#(
  parameter int NB_SPMS = NB_SPMS_DFLT,
  parameter int IDX_W   = IDX_W_DFLT
) (
  input  logic             mclk,
  input  logic             puc_rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [15:0]      r12,
  input  logic [15:0]      r13,
  input  logic [15:0]      r14,
  input  logic [15:0]      r15,
  input  logic [15:0]      pc,
  output logic [IDX_W-1:0] slot_sel,
  input  logic             slot_enabled,
  input  logic [15:0]      slot_pub_start,
  input  logic [15:0]      slot_pub_end,
  input  logic [15:0]      slot_sec_start,
  input  logic [15:0]      slot_sec_end,
  output logic             slot_wr,
  output logic             slot_clr,
  output logic [63:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             ok,
  output logic [2:0]       err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SPMS - 1);

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [15:0]      r12_q, r12_d, r13_q, r13_d, r14_q, r14_d, r15_q, r15_d, pc_q, pc_d;
  logic [IDX_W-1:0] idx_q, idx_d, tgt_q, tgt_d;
  logic             free_q, free_d;
  logic             slot_wr_q, slot_wr_d, slot_clr_q, slot_clr_d;
  logic             busy_q, busy_d, done_q, done_d, ok_q, ok_d;
  logic [2:0]       err_q, err_d;

  logic hit_layout, hit_pp, hit_ps, hit_sp, hit_ss;
  logic layout_ok, scan_hit, pc_match;

  omsp_spm_range_cmp u_cmp_layout (.a0(r12_q), .a1(r13_q), .b0(r14_q), .b1(r15_q), .hit(hit_layout));
  omsp_spm_range_cmp u_cmp_pp (.a0(r12_q), .a1(r13_q), .b0(slot_pub_start), .b1(slot_pub_end), .hit(hit_pp));
  omsp_spm_range_cmp u_cmp_ps (.a0(r12_q), .a1(r13_q), .b0(slot_sec_start), .b1(slot_sec_end), .hit(hit_ps));
  omsp_spm_range_cmp u_cmp_sp (.a0(r14_q), .a1(r15_q), .b0(slot_pub_start), .b1(slot_pub_end), .hit(hit_sp));
  omsp_spm_range_cmp u_cmp_ss (.a0(r14_q), .a1(r15_q), .b0(slot_sec_start), .b1(slot_sec_end), .hit(hit_ss));

  assign layout_ok = (r12_q < r13_q) && (r14_q < r15_q) && !hit_layout;
  assign scan_hit  = slot_enabled && (hit_pp || hit_ps || hit_sp || hit_ss);
  assign pc_match  = slot_enabled && (pc_q >= slot_pub_start) && (pc_q < slot_pub_end);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= 1'b0;
      r12_q      <= '0;
      r13_q      <= '0;
      r14_q      <= '0;
      r15_q      <= '0;
      pc_q       <= '0;
      idx_q      <= '0;
      tgt_q      <= '0;
      free_q     <= 1'b0;
      slot_wr_q  <= 1'b0;
      slot_clr_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      r12_q      <= r12_d;
      r13_q      <= r13_d;
      r14_q      <= r14_d;
      r15_q      <= r15_d;
      pc_q       <= pc_d;
      idx_q      <= idx_d;
      tgt_q      <= tgt_d;
      free_q     <= free_d;
      slot_wr_q  <= slot_wr_d;
      slot_clr_q <= slot_clr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r12_d   = r12_q;
    r13_d   = r13_q;
    r14_d   = r14_q;
    r15_d   = r15_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    free_d  = free_q;
    ok_d    = ok_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          r12_d   = r12;
          r13_d   = r13;
          r14_d   = r14;
          r15_d   = r15;
          pc_d    = pc;
          ok_d    = 1'b0;
          err_d   = ERR_NONE;
          idx_d   = '0;
          tgt_d   = '0;
          free_d  = 1'b0;
          state_d = (op == OP_UNPROTECT) ? ST_SCAN : ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        idx_d = '0;
        if (layout_ok) begin
          state_d = ST_SCAN;
        end else begin
          err_d   = ERR_LAYOUT;
          state_d = ST_DONE;
        end
      end
      ST_SCAN: begin
        if (op_q == OP_PROTECT) begin
          if (scan_hit) begin
            err_d   = ERR_OVERLAP;
            state_d = ST_DONE;
          end else begin
            if (!slot_enabled && !free_q) begin
              free_d = 1'b1;
              tgt_d  = idx_q;
            end
            // free_d already includes a free slot found on this last cycle
            if (idx_q == LAST_IDX) begin
              if (free_d) begin
                state_d = ST_COMMIT;
              end else begin
                err_d   = ERR_FULL;
                state_d = ST_DONE;
              end
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else begin
          if (pc_match) begin
            tgt_d   = idx_q;
            state_d = ST_COMMIT;
          end else if (idx_q == LAST_IDX) begin
            err_d   = ERR_NOT_FOUND;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_COMMIT: begin
        ok_d    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    slot_wr_d  = (state_d == ST_COMMIT) && (op_q == OP_PROTECT);
    slot_clr_d = (state_d == ST_COMMIT) && (op_q == OP_UNPROTECT);
    done_d     = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  always_comb begin
    slot_sel = '0;
    case (state_q)
      ST_SCAN:   slot_sel = idx_q;
      ST_COMMIT: slot_sel = tgt_q;
      default:   slot_sel = '0;
    endcase
  end

  assign slot_wr  = slot_wr_q;
  assign slot_clr = slot_clr_q;
  assign wr_data  = {r12_q, r13_q, r14_q, r15_q};
  assign busy     = busy_q;
  assign done     = done_q;
  assign ok       = ok_q;
  assign err      = err_q;

endmodule
